// File: rtl/vdp_sprite_line_scanner_pkg.sv
// rtl/vdp_sprite_line_scanner_pkg.sv - shared field layout, states and helpers for the sprite line scanner
package vdp_sprite_line_scanner_pkg;

    // Y attribute word fields, as bit offsets above the Y_WIDTH-wide y coordinate
    localparam int YA_FLIP_OFS = 0;
    localparam int YA_HH_OFS   = 1;
    localparam int YA_S_OFS    = 3;
    localparam int YA_D_OFS    = 4;
    localparam int YA_USED_W   = 5;

    // Hit entry tag {T, S, offset[5:0]} sits directly above the sprite id
    localparam int HE_OFFSET_W = 6;
    localparam int HE_TAG_W    = 8;
    localparam logic [HE_TAG_W-1:0] HIT_TERM_TAG = 8'h80;

    // Scanner FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_TERM = 2'd2;

    typedef struct packed {
        logic                   hit;
        logic [HE_OFFSET_W-1:0] offset;
    } y_isect_t;

    // Sprite height in lines for a 2-bit height code: 8, 16, 32 or 64
    function automatic logic [6:0] sprite_height(input logic [1:0] hh);
        return 7'd8 << hh;
    endfunction

    // Tag of a regular hit entry (terminator bit clear)
    function automatic logic [HE_TAG_W-1:0] hit_tag(input logic s, input logic [HE_OFFSET_W-1:0] offset);
        return {1'b0, s, offset};
    endfunction

endpackage

// File: rtl/vdp_sprite_y_intersect.sv
// rtl/vdp_sprite_y_intersect.sv - combinational sprite/raster-line vertical intersection test
module vdp_sprite_y_intersect
    import vdp_sprite_line_scanner_pkg::*;
#(
    parameter int Y_WIDTH = 9
) (
    input  logic [Y_WIDTH-1:0] y_i,
    input  logic [1:0]         hh_i,
    input  logic               flip_i,
    input  logic               disable_i,
    input  logic [Y_WIDTH-1:0] target_y_i,
    output y_isect_t           isect_o
);

    logic [Y_WIDTH-1:0] diff;
    logic [Y_WIDTH-1:0] height;

    // Modular distance below the sprite top so sprites straddling line 0 still hit;
    // the 6-bit offset arithmetic is exact because a hit implies diff < 64
    always_comb begin
        diff           = target_y_i - y_i;
        height         = Y_WIDTH'(sprite_height(hh_i));
        isect_o.hit    = !disable_i && (diff < height);
        isect_o.offset = flip_i ? (height[HE_OFFSET_W-1:0] - 6'd1 - diff[HE_OFFSET_W-1:0])
                                : diff[HE_OFFSET_W-1:0];
    end

endmodule

// File: rtl/vdp_sprite_line_scanner.sv
// rtl/vdp_sprite_line_scanner.sv - per-line Y RAM scan producing the blitter hit list
module vdp_sprite_line_scanner
    import vdp_sprite_line_scanner_pkg::*;
#(
    parameter int SPRITE_COUNT = 256,
    parameter int ID_WIDTH     = 8,
    parameter int Y_WIDTH      = 9,
    parameter int MAX_HITS     = 64,
    parameter int HIT_AW       = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_new_line,
    input  logic [Y_WIDTH-1:0]    target_y,
    output logic [ID_WIDTH-1:0]   y_read_address,
    input  logic [15:0]           y_read_data,
    output logic                  hit_write_en,
    output logic [HIT_AW-1:0]     hit_write_address,
    output logic [ID_WIDTH+7:0]   hit_write_data,
    output logic                  busy,
    output logic                  done,
    output logic [HIT_AW-1:0]     hit_count,
    output logic                  overflow
);

    localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(SPRITE_COUNT - 1);
    localparam logic [HIT_AW-1:0]   HIT_LIMIT = HIT_AW'(MAX_HITS);

    logic [1:0]          state_q, state_d;
    logic [Y_WIDTH-1:0]  target_q, target_d;
    logic [ID_WIDTH-1:0] addr_q, addr_d;
    logic                issue_q, issue_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [ID_WIDTH-1:0] cmp_id_q, cmp_id_d;
    logic                wr_en_q, wr_en_d;
    logic [HIT_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [ID_WIDTH+7:0] wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [HIT_AW-1:0]   hit_count_q, hit_count_d;
    logic                overflow_q, overflow_d;

    y_isect_t            isect;
    logic                unused_y_bits;

    assign unused_y_bits = ^y_read_data[15:Y_WIDTH+YA_USED_W];

    vdp_sprite_y_intersect #(
        .Y_WIDTH (Y_WIDTH)
    ) u_y_intersect (
        .y_i        (y_read_data[Y_WIDTH-1:0]),
        .hh_i       (y_read_data[Y_WIDTH+YA_HH_OFS +: 2]),
        .flip_i     (y_read_data[Y_WIDTH+YA_FLIP_OFS]),
        .disable_i  (y_read_data[Y_WIDTH+YA_D_OFS]),
        .target_y_i (target_q),
        .isect_o    (isect)
    );

    // Next state: address issue, one-cycle compare stage, hit list write and terminator;
    // a new start overrides everything so in-flight work of an aborted line is dropped
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        addr_d      = addr_q;
        issue_d     = issue_q;
        cmp_valid_d = 1'b0;
        cmp_id_d    = cmp_id_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = done_q ? 1'b0 : busy_q;
        done_d      = 1'b0;
        hit_count_d = hit_count_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_SCAN: begin
                cmp_valid_d = issue_q;
                cmp_id_d    = addr_q;
                if (issue_q) begin
                    if (addr_q == LAST_ID) begin
                        issue_d = 1'b0;
                    end else begin
                        addr_d = addr_q + ID_WIDTH'(1);
                    end
                end
                if (cmp_valid_q) begin
                    if (isect.hit) begin
                        if (hit_count_q < HIT_LIMIT) begin
                            wr_en_d     = 1'b1;
                            wr_addr_d   = hit_count_q;
                            wr_data_d   = {hit_tag(y_read_data[Y_WIDTH+YA_S_OFS], isect.offset), cmp_id_q};
                            hit_count_d = hit_count_q + HIT_AW'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (cmp_id_q == LAST_ID) begin
                        state_d = ST_TERM;
                    end
                end
            end
            ST_TERM: begin
                wr_en_d   = 1'b1;
                wr_addr_d = hit_count_q;
                wr_data_d = {HIT_TERM_TAG, {ID_WIDTH{1'b0}}};
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
            end
        endcase

        if (start_new_line) begin
            state_d     = ST_SCAN;
            target_d    = target_y;
            addr_d      = '0;
            issue_d     = 1'b1;
            cmp_valid_d = 1'b0;
            wr_en_d     = 1'b0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            hit_count_d = '0;
            overflow_d  = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over a start pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            addr_q      <= '0;
            issue_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_id_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            addr_q      <= addr_d;
            issue_q     <= issue_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_id_q    <= cmp_id_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_count_q <= hit_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign y_read_address    = addr_q;
    assign hit_write_en      = wr_en_q;
    assign hit_write_address = wr_addr_q;
    assign hit_write_data    = wr_data_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign hit_count         = hit_count_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_vdp_sprite_line_scanner.sv
// tb/tb_vdp_sprite_line_scanner.sv - self-checking bench for vdp_sprite_line_scanner
module tb_vdp_sprite_line_scanner;

    localparam int N   = 64;
    localparam int IDW = 6;
    localparam int YW  = 9;
    localparam int MH  = 4;
    localparam int HAW = 3;
    localparam logic [13:0] TERM_WORD = 14'h2000;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_new_line;
    logic [YW-1:0]   target_y;
    logic [IDW-1:0]  y_read_address;
    logic [15:0]     y_read_data;
    logic            hit_write_en;
    logic [HAW-1:0]  hit_write_address;
    logic [IDW+7:0]  hit_write_data;
    logic            busy;
    logic            done;
    logic [HAW-1:0]  hit_count;
    logic            overflow;

    logic [15:0] ram [N];
    logic [16:0] wq [$];
    logic [13:0] exp_q [$];
    bit          exp_ovf;
    int          done_cnt;
    int          tests = 0;
    int          fails = 0;
    logic [16:0] first;

    vdp_sprite_line_scanner #(
        .SPRITE_COUNT (N),
        .ID_WIDTH     (IDW),
        .Y_WIDTH      (YW),
        .MAX_HITS     (MH),
        .HIT_AW       (HAW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start_new_line    (start_new_line),
        .target_y          (target_y),
        .y_read_address    (y_read_address),
        .y_read_data       (y_read_data),
        .hit_write_en      (hit_write_en),
        .hit_write_address (hit_write_address),
        .hit_write_data    (hit_write_data),
        .busy              (busy),
        .done              (done),
        .hit_count         (hit_count),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    // Y attribute RAM with one cycle read latency
    always @(posedge clk) y_read_data <= ram[y_read_address];

    // Hit list write and done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (hit_write_en) wq.push_back({hit_write_address, hit_write_data});
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int y, input int flip, input int hh, input int s, input int d);
        return 16'((d << 13) | (s << 12) | (hh << 10) | (flip << 9) | (y & 511));
    endfunction

    task automatic clear_ram();
        for (int i = 0; i < N; i++) ram[i] = 16'($urandom) | 16'h2000;
    endtask

    // Reference: walk sprites in id order applying the intersection rule and the hit limit
    function automatic void build_expected(input int t);
        exp_q.delete();
        exp_ovf = 0;
        for (int id = 0; id < N; id++) begin
            logic [15:0] w;
            int y, flip, hh, s, d, diff, h, off;
            w    = ram[id];
            y    = int'(w[8:0]);
            flip = int'(w[9]);
            hh   = int'(w[11:10]);
            s    = int'(w[12]);
            d    = int'(w[13]);
            diff = (t - y + 512) % 512;
            h    = 8 << hh;
            if (d == 0 && diff < h) begin
                off = flip ? (h - 1 - diff) : diff;
                if (exp_q.size() < MH) exp_q.push_back(14'((s << 12) | (off << 6) | id));
                else exp_ovf = 1;
            end
        end
    endfunction

    task automatic pulse_start(input int t);
        start_new_line = 1'b1;
        target_y       = YW'(t);
        @(posedge clk); #1;
        start_new_line = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat = 1;
        int n;
        while (!done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, N + 3);
        @(negedge clk); #1;
        check({tag, " writes"}, wq.size(), exp_q.size() + 1);
        n = (wq.size() < exp_q.size() + 1) ? wq.size() : exp_q.size() + 1;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s wr%0d addr", tag, i), 32'(wq[i][16:14]), i);
            check($sformatf("%s wr%0d data", tag, i), 32'(wq[i][13:0]),
                  (i < exp_q.size()) ? 32'(exp_q[i]) : 32'(TERM_WORD));
        end
        check({tag, " hit_count"}, 32'(hit_count), exp_q.size());
        check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        first = (wq.size() > 0) ? wq[0] : '1;
        @(posedge clk); #1;
        check({tag, " busy after"}, 32'(busy), 0);
        check({tag, " done width"}, 32'(done), 0);
        check({tag, " done count"}, done_cnt, 1);
    endtask

    task automatic run_line(input int t, input string tag);
        wq.delete();
        done_cnt = 0;
        build_expected(t);
        pulse_start(t);
        wait_done(tag);
    endtask

    initial begin
        reset          = 1'b1;
        start_new_line = 1'b0;
        target_y       = '0;
        clear_ram();
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst wr_en", 32'(hit_write_en), 0);
        check("rst wr_addr", 32'(hit_write_address), 0);
        check("rst wr_data", 32'(hit_write_data), 0);
        check("rst rd_addr", 32'(y_read_address), 0);
        check("rst hit_count", 32'(hit_count), 0);
        check("rst overflow", 32'(overflow), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single 16px sprite, offset 7
        clear_ram();
        ram[3] = mk(100, 0, 1, 0, 0);
        run_line(107, "spr3");
        check("spr3 entry", 32'(first[13:0]), 32'h01C3);

        // 64px flipped sprite, then the same sprite disabled
        clear_ram();
        ram[5] = mk(100, 1, 3, 0, 0);
        run_line(110, "spr5");
        check("spr5 entry", 32'(first[13:0]), 32'h0D45);
        ram[5] = mk(100, 1, 3, 0, 1);
        run_line(110, "spr5 dis");

        // Wrap across line 0 and the bottom height boundary
        clear_ram();
        ram[7] = mk(508, 0, 1, 1, 0);
        run_line(3, "wrap3");
        check("wrap3 entry", 32'(first[13:0]), 32'h11C7);
        run_line(11, "wrap11");
        check("wrap11 entry", 32'(first[13:0]), 32'h13C7);
        run_line(12, "wrap12");

        // Hit limit overflow, then a line exactly at the limit
        clear_ram();
        for (int i = 0; i < 10; i++) ram[i] = mk(100, 0, 0, 0, 0);
        run_line(100, "ovf");
        for (int i = 4; i < 10; i++) ram[i] = mk(100, 0, 0, 0, 1);
        run_line(100, "at limit");

        // Restart mid-scan while a write is in flight
        clear_ram();
        for (int i = 0; i < 10; i++) ram[i] = mk(100, 0, 0, 0, 0);
        ram[20] = mk(200, 0, 0, 1, 0);
        ram[48] = mk(200, 0, 0, 0, 0);
        wq.delete();
        done_cnt = 0;
        pulse_start(200);
        repeat (48) begin
            @(posedge clk); #1;
        end
        wq.delete();
        build_expected(100);
        pulse_start(100);
        wait_done("abort");

        // Reset together with start mid-scan
        pulse_start(100);
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("pre-rst overflow", 32'(overflow), 1);
        reset          = 1'b1;
        start_new_line = 1'b1;
        target_y       = 9'd100;
        @(posedge clk); #1;
        reset          = 1'b0;
        start_new_line = 1'b0;
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        check("midrst wr_en", 32'(hit_write_en), 0);
        check("midrst overflow", 32'(overflow), 0);
        check("midrst hit_count", 32'(hit_count), 0);
        wq.delete();
        done_cnt = 0;
        repeat (100) begin
            @(posedge clk); #1;
        end
        check("midrst no writes", wq.size(), 0);
        check("midrst no done", done_cnt, 0);
        check("midrst idle", 32'(busy), 0);

        // Randomised lines against the reference
        for (int r = 0; r < 8; r++) begin
            int t;
            t = $urandom_range(0, 511);
            for (int i = 0; i < N; i++) begin
                int y;
                y = (t + 512 - $urandom_range(0, 80)) % 512;
                if ($urandom_range(0, 5) == 0)
                    ram[i] = mk(y, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), 0)
                             | (16'($urandom_range(0, 3)) << 14);
                else
                    ram[i] = 16'($urandom) | 16'h2000;
            end
            run_line(t, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
